// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// boot PC, NOP word and the address-error exception code.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_HOLD      = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL  = 5'h04;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction read channel between the fetch controller (master)
// and the instruction memory (slave).
interface inst_fetch_ctrl_if #(parameter int WIDTH = 32);
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [WIDTH-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_skid_buf.sv
// Single-entry instruction+PC holding buffer used while decode is stalled
// at the moment the fetched word returns.
module inst_skid_buf #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drop_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  // Drop takes priority so a flushed entry can never be handed to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (drop_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like read, IF/ID register
// with stall/flush handling. Optional alignment check under FETCH_ADDR_CHECK_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pcF,
  input  logic              ceF,
  input  logic              stallD,
  input  logic              flushD,
  inst_fetch_ctrl_if.master bus,
  output logic              stallF,
  output logic [WIDTH-1:0]  instrD,
  output logic [WIDTH-1:0]  pcD,
  output logic              validD
`ifdef FETCH_ADDR_CHECK_EN
  ,
  output logic              addr_errD
`endif
);

  fetch_state_e     state_q;
  logic [WIDTH-1:0] addr_q;
  logic             discard_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;

  logic             misalign_s;
  logic             issue_s;
  logic             err_fetch_s;
  logic             data_hit_s;
  logic             deliver_s;
  logic             park_s;
  logic             unpark_s;
  logic             complete_s;
  logic             buf_valid_s;
  logic [WIDTH-1:0] buf_instr_s;
  logic [WIDTH-1:0] buf_pc_s;

`ifdef FETCH_ADDR_CHECK_EN
  logic aerr_q;
  assign misalign_s = addr_misaligned(pcF[1:0]);
  assign addr_errD  = aerr_q;
`else
  assign misalign_s = 1'b0;
`endif

  assign issue_s     = (state_q == S_IDLE) & ceF & ~flushD & ~misalign_s;
  assign err_fetch_s = (state_q == S_IDLE) & ceF & ~flushD & misalign_s & ~stallD;
  // A word returning while flush is pending or asserted is consumed silently.
  assign data_hit_s  = (state_q == S_WAIT_DATA) & bus.inst_data_ok & ~discard_q & ~flushD;
  assign deliver_s   = data_hit_s & ~stallD;
  assign park_s      = data_hit_s & stallD;
  assign unpark_s    = (state_q == S_HOLD) & buf_valid_s & ~stallD & ~flushD;
  assign complete_s  = deliver_s | unpark_s | err_fetch_s;

  assign bus.inst_req  = ~rst & (issue_s | (state_q == S_WAIT_ADDR));
  assign bus.inst_addr = rst ? '0 : ((state_q == S_IDLE) ? pcF : addr_q);
  assign stallF        = rst ? 1'b0 : (stallD ? 1'b1 : (ceF ? ~complete_s : 1'b0));

  inst_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (park_s),
    .drop_i  ((state_q == S_HOLD) & (flushD | ~stallD)),
    .instr_i (bus.inst_rdata),
    .pc_i    (addr_q),
    .valid_o (buf_valid_s),
    .instr_o (buf_instr_s),
    .pc_o    (buf_pc_s)
  );

  // Fetch FSM plus the IF/ID register it feeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= WIDTH'(RESET_PC);
      discard_q <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
      aerr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_s) begin
            addr_q    <= pcF;
            discard_q <= 1'b0;
            state_q   <= bus.inst_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_ADDR: begin
          // An address accepted together with a flush must still be drained.
          if (bus.inst_addr_ok) begin
            state_q   <= S_WAIT_DATA;
            discard_q <= flushD;
          end else if (flushD) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_ADDR;
          end
        end
        S_WAIT_DATA: begin
          if (bus.inst_data_ok) begin
            state_q   <= park_s ? S_HOLD : S_IDLE;
            discard_q <= 1'b0;
          end else if (flushD) begin
            discard_q <= 1'b1;
          end else begin
            state_q <= S_WAIT_DATA;
          end
        end
        S_HOLD: begin
          if (flushD || !stallD) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (flushD) begin
        valid_q <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
        aerr_q  <= 1'b0;
`endif
      end else if (deliver_s) begin
        instr_q <= bus.inst_rdata;
        pc_q    <= addr_q;
        valid_q <= 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
        aerr_q  <= 1'b0;
`endif
      end else if (unpark_s) begin
        instr_q <= buf_instr_s;
        pc_q    <= buf_pc_s;
        valid_q <= 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
        aerr_q  <= 1'b0;
`endif
      end else if (err_fetch_s) begin
        instr_q <= WIDTH'(NOP_INSTR);
        pc_q    <= pcF;
        valid_q <= 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
        aerr_q  <= 1'b1;
`endif
      end else if (!stallD) begin
        valid_q <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
        aerr_q  <= 1'b0;
`endif
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign instrD = instr_q;
  assign pcD    = pc_q;
  assign validD = valid_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: transaction-level model checked every
// negedge, plus literal expectations at key points of each scenario.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcF = 32'h0;
  logic        ceF = 1'b0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        stallF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        addr_errD;

  int checks = 0;
  int errors = 0;

  inst_fetch_ctrl_if #(.WIDTH(32)) bus ();

  inst_fetch_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .pcF    (pcF),
    .ceF    (ceF),
    .stallD (stallD),
    .flushD (flushD),
    .bus    (bus),
    .stallF (stallF),
    .instrD (instrD),
    .pcD    (pcD),
`ifdef FETCH_ADDR_CHECK_EN
    .addr_errD (addr_errD),
`endif
    .validD (validD)
  );

`ifndef FETCH_ADDR_CHECK_EN
  assign addr_errD = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: what the fetch stage owes decode ----------------
  logic        m_valid = 1'b0, m_aerr = 1'b0;
  logic [31:0] m_instr = 32'h0, m_pc = 32'h0;
  logic        m_waddr = 1'b0;   // request issued, address not yet accepted
  logic        m_wdata = 1'b0;   // address accepted, word outstanding
  logic        m_drop  = 1'b0;   // outstanding word belongs to a squashed fetch
  logic        m_held  = 1'b0;   // word returned while decode stalled
  logic [31:0] m_hword = 32'h0;
  logic [31:0] m_fpc   = 32'h0;

  always @(negedge clk) begin
    logic e_idle, e_mis, e_err, e_done, e_req, e_stf;
    e_idle = !m_waddr && !m_wdata && !m_held;
`ifdef FETCH_ADDR_CHECK_EN
    e_mis = (pcF[1:0] != 2'b00);
`else
    e_mis = 1'b0;
`endif
    e_err  = e_idle && ceF && !flushD && e_mis && !stallD;
    e_req  = !rst && ((e_idle && ceF && !flushD && !e_mis) || m_waddr);
    e_done = (m_wdata && bus.inst_data_ok && !m_drop && !flushD && !stallD)
           || (m_held && !stallD && !flushD) || e_err;
    e_stf  = rst ? 1'b0 : (stallD ? 1'b1 : (ceF ? !e_done : 1'b0));

    chk("m_validD", {31'h0, validD}, {31'h0, rst ? 1'b0 : m_valid});
    chk("m_addr_errD", {31'h0, addr_errD}, {31'h0, rst ? 1'b0 : m_aerr});
    chk("m_inst_req", {31'h0, bus.inst_req}, {31'h0, e_req});
    chk("m_stallF", {31'h0, stallF}, {31'h0, e_stf});
    if (rst) begin
      chk("m_instrD_rst", instrD, 32'h0);
      chk("m_pcD_rst", pcD, 32'h0);
      chk("m_inst_addr_rst", bus.inst_addr, 32'h0);
    end else begin
      if (m_valid) begin
        chk("m_instrD", instrD, m_instr);
        chk("m_pcD", pcD, m_pc);
      end
      if (e_req) chk("m_inst_addr", bus.inst_addr, m_waddr ? m_fpc : pcF);
    end

    // advance the model to the state after the coming rising edge
    if (rst) begin
      m_valid = 1'b0; m_aerr = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
      m_waddr = 1'b0; m_wdata = 1'b0; m_drop = 1'b0; m_held = 1'b0;
    end else begin
      if (flushD) begin
        m_valid = 1'b0; m_aerr = 1'b0;
      end else if (m_wdata && bus.inst_data_ok && !m_drop && !stallD) begin
        m_valid = 1'b1; m_aerr = 1'b0; m_instr = bus.inst_rdata; m_pc = m_fpc;
      end else if (m_held && !stallD) begin
        m_valid = 1'b1; m_aerr = 1'b0; m_instr = m_hword; m_pc = m_fpc;
      end else if (e_err) begin
        m_valid = 1'b1; m_aerr = 1'b1; m_instr = 32'h0; m_pc = pcF;
      end else if (!stallD) begin
        m_valid = 1'b0; m_aerr = 1'b0;
      end

      if (e_idle && ceF && !flushD && !e_mis) begin
        m_fpc = pcF;
        m_drop = 1'b0;
        if (bus.inst_addr_ok) m_wdata = 1'b1;
        else m_waddr = 1'b1;
      end else if (m_waddr) begin
        if (bus.inst_addr_ok) begin
          m_waddr = 1'b0; m_wdata = 1'b1; m_drop = flushD;
        end else if (flushD) begin
          m_waddr = 1'b0;
        end
      end else if (m_wdata) begin
        if (bus.inst_data_ok) begin
          m_wdata = 1'b0;
          if (!m_drop && !flushD && stallD) begin
            m_held = 1'b1; m_hword = bus.inst_rdata;
          end
          m_drop = 1'b0;
        end else if (flushD) begin
          m_drop = 1'b1;
        end
      end else if (m_held) begin
        if (flushD || !stallD) m_held = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic ce, input logic [31:0] pc, input logic st, input logic fl,
                     input logic aok, input logic dok, input logic [31:0] rd);
    ceF = ce; pcF = pc; stallD = st; flushD = fl;
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
    #1;
  endtask

  initial begin
    set(1'b1, 32'hbfc0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(); cyc();
    chk("rst_validD", {31'h0, validD}, 32'h0);
    chk("rst_inst_req", {31'h0, bus.inst_req}, 32'h0);
    chk("rst_stallF", {31'h0, stallF}, 32'h0);
    chk("rst_instrD", instrD, 32'h0);
    rst = 1'b0;
    set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();

    // zero-wait fetch
    set(1'b1, 32'hbfc0_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("zw_req", {31'h0, bus.inst_req}, 32'h1);
    chk("zw_addr", bus.inst_addr, 32'hbfc0_0000);
    chk("zw_stallF_busy", {31'h0, stallF}, 32'h1);
    cyc();
    set(1'b1, 32'hbfc0_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3c1d_8000);
    chk("zw_stallF_done", {31'h0, stallF}, 32'h0);
    chk("zw_req_waitdata", {31'h0, bus.inst_req}, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("zw_validD", {31'h0, validD}, 32'h1);
    chk("zw_instrD", instrD, 32'h3c1d_8000);
    chk("zw_pcD", pcD, 32'hbfc0_0000);
    cyc();

    // address backpressure
    set(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", {31'h0, bus.inst_req}, 32'h1);
      chk("bp_addr", bus.inst_addr, 32'hbfc0_0004);
      chk("bp_stallF", {31'h0, stallF}, 32'h1);
      cyc();
    end
    set(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8c02_0010);
    cyc();
    set(1'b0, 32'hbfc0_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bp_instrD", instrD, 32'h8c02_0010);
    chk("bp_pcD", pcD, 32'hbfc0_0004);
    cyc();

    // decode stall at data return
    set(1'b1, 32'hbfc0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0008, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2402_0001);
    cyc();
    set(1'b1, 32'hbfc0_0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_validD", {31'h0, validD}, 32'h0);
      chk("hold_req", {31'h0, bus.inst_req}, 32'h0);
      cyc();
    end
    set(1'b1, 32'hbfc0_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hold_stallF_done", {31'h0, stallF}, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_000c, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hold_instrD", instrD, 32'h2402_0001);
    chk("hold_pcD", pcD, 32'hbfc0_0008);
    cyc(); cyc();
    chk("stall_keep_valid", {31'h0, validD}, 32'h1);
    chk("stall_keep_instr", instrD, 32'h2402_0001);

    // reset in the middle of a fetch, then a stray data_ok
    set(1'b1, 32'hbfc0_0020, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_0020, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", {31'h0, validD}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_validD", {31'h0, validD}, 32'h0);
    chk("mid_rst_instrD", instrD, 32'h0);
    chk("mid_rst_pcD", pcD, 32'h0);
    chk("mid_rst_stallF", {31'h0, stallF}, 32'h0);
    cyc();
    rst = 1'b0;
    set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hffff_ffff);
    cyc();
    set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stray_validD", {31'h0, validD}, 32'h0);
    cyc();

    // flush while waiting for data, then redirected fetch
    set(1'b1, 32'hbfc0_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0380, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0380, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_no_new_req", {31'h0, bus.inst_req}, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0380, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef);
    cyc();
    set(1'b1, 32'hbfc0_0380, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("fl_discard_validD", {31'h0, validD}, 32'h0);
    chk("fl_new_req", {31'h0, bus.inst_req}, 32'h1);
    chk("fl_new_addr", bus.inst_addr, 32'hbfc0_0380);
    cyc();
    set(1'b1, 32'hbfc0_0380, 1'b0, 1'b0, 1'b0, 1'b1, 32'h27bd_fff8);
    cyc();
    set(1'b0, 32'hbfc0_0384, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_next_instrD", instrD, 32'h27bd_fff8);
    chk("fl_next_pcD", pcD, 32'hbfc0_0380);
    cyc();

    // flush coinciding with data_ok
    set(1'b1, 32'hbfc0_0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_0010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111);
    cyc();
    set(1'b0, 32'hbfc0_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_data_validD", {31'h0, validD}, 32'h0);
    cyc();

    // flush while the address is still pending
    set(1'b1, 32'hbfc0_0014, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0014, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("fl_wa_req_held", {31'h0, bus.inst_req}, 32'h1);
    cyc();
    set(1'b0, 32'hbfc0_0014, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_wa_withdrawn", {31'h0, bus.inst_req}, 32'h0);
    cyc();

    // flush while a word is parked
    set(1'b1, 32'hbfc0_0018, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    set(1'b1, 32'hbfc0_0018, 1'b1, 1'b0, 1'b0, 1'b1, 32'haaaa_5555);
    cyc();
    set(1'b0, 32'hbfc0_0018, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_0018, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(); cyc();
    chk("fl_hold_dropped", {31'h0, validD}, 32'h0);

`ifdef FETCH_ADDR_CHECK_EN
    // misaligned fetch completes locally with an address error
    set(1'b1, 32'hbfc0_0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("ae_no_req", {31'h0, bus.inst_req}, 32'h0);
    chk("ae_stallF", {31'h0, stallF}, 32'h0);
    cyc();
    set(1'b0, 32'hbfc0_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ae_addr_errD", {31'h0, addr_errD}, 32'h1);
    chk("ae_validD", {31'h0, validD}, 32'h1);
    chk("ae_instrD", instrD, 32'h0);
    chk("ae_pcD", pcD, 32'hbfc0_0002);
    cyc();
`endif

    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
